md_scheduler: RTL and testbench

Multicycle multiply/divide controller between the decode stage and the HI/LO registers. Accepts MULT/MULTU/DIV/DIVU requests from decode and sequences a pipelined multiplier or a 32-iteration radix-2 divider. Returns one 64-bit {HI,LO} result with a one-cycle completion pulse. Raises a pipeline stall for any instruction that would use or clobber HI/LO while an operation is outstanding.

---
 rtl/md_pkg.sv | 17 +
 rtl/md_if.sv | 27 ++
 rtl/md_div_iter.sv | 47 ++++
 rtl/md_scheduler.sv | 126 ++++++++++++
 tb/tb_md_scheduler.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package md_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_if.sv
// Decode-side request / HI-LO result bundle of the multiply/divide scheduler.
interface md_if;

  logic                             mult_en;
  logic                             div_en;
  logic                             is_signed;
  logic [md_pkg::XLEN-1:0]          src1;
  logic [md_pkg::XLEN-1:0]          src2;
  logic                             flush;
  logic                             hilo_rd;
  logic                             hilo_wr;
  logic                             md_stall;
  logic                             md_busy;
  logic                             md_complete;
  logic [2*md_pkg::XLEN-1:0]        md_result;

  modport master (
    output mult_en, div_en, is_signed, src1, src2, flush, hilo_rd, hilo_wr,
    input  md_stall, md_busy, md_complete, md_result
  );

  modport slave (
    input  mult_en, div_en, is_signed, src1, src2, flush, hilo_rd, hilo_wr,
    output md_stall, md_busy, md_complete, md_result
  );

endinterface

// File: rtl/md_div_iter.sv
// Unsigned radix-2 restoring divider datapath; one shift-subtract per step.
// Outputs are the post-step values so the final step can be captured directly.
module md_div_iter
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem_nxt,
  output logic [XLEN-1:0] o_quo_nxt
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  // Quotient register doubles as the dividend shift-out register.
  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_ge      = ~w_diff[XLEN];
    o_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    o_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= o_rem_nxt;
      r_quo <= o_quo_nxt;
    end
  end

endmodule

// File: rtl/md_scheduler.sv
// Multicycle MULT/MULTU/DIV/DIVU controller feeding HI/LO, with decode stall.
module md_scheduler
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input logic  clk,
  input logic  reset,
  md_if.slave  bus
);

  md_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]   r_src1, r_src2;
  logic              r_signed, r_qneg, r_rneg, r_dbz;
  logic [2*XLEN-1:0] r_result, w_result_nxt;
  logic              w_accept, w_load, w_step;
  logic [XLEN-1:0]   w_abs1, w_abs2;
  logic [XLEN-1:0]   w_rem_raw, w_quo_raw, w_rem_fix, w_quo_fix;
  logic [2*XLEN-1:0] w_ext1, w_ext2, w_prod;

  assign w_accept = (r_state == S_IDLE) & (bus.mult_en | bus.div_en) & ~bus.flush;
  assign w_abs1   = (bus.is_signed & bus.src1[XLEN-1]) ? (~bus.src1 + XLEN'(1)) : bus.src1;
  assign w_abs2   = (bus.is_signed & bus.src2[XLEN-1]) ? (~bus.src2 + XLEN'(1)) : bus.src2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src1   <= '0;
      r_src2   <= '0;
      r_signed <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_src1   <= bus.src1;
      r_src2   <= bus.src2;
      r_signed <= bus.is_signed;
      r_qneg   <= bus.is_signed & (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
      r_rneg   <= bus.is_signed & bus.src1[XLEN-1];
      r_dbz    <= (bus.src2 == '0);
    end
  end

  // Full 64-bit product; sign extension makes the truncated product correct for MULT.
  assign w_ext1 = {{XLEN{r_signed & r_src1[XLEN-1]}}, r_src1};
  assign w_ext2 = {{XLEN{r_signed & r_src2[XLEN-1]}}, r_src2};
  assign w_prod = w_ext1 * w_ext2;

  md_div_iter u_div (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (w_abs1),
    .i_divisor  (w_abs2),
    .o_rem_nxt  (w_rem_raw),
    .o_quo_nxt  (w_quo_raw)
  );

  assign w_quo_fix = r_qneg ? (~w_quo_raw + XLEN'(1)) : w_quo_raw;
  assign w_rem_fix = r_rneg ? (~w_rem_raw + XLEN'(1)) : w_rem_raw;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.div_en) begin
            w_state_nxt = S_DIV;
            w_cnt_nxt   = CNT_W'(DIV_ITERS - 1);
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_MUL;
            w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
          end
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_result_nxt = w_prod;
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DIV: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_result_nxt = r_dbz ? {r_src1, DIV0_LO} : {w_rem_fix, w_quo_fix};
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.md_busy     = (r_state != S_IDLE);
  assign bus.md_complete = (r_state == S_DONE);
  assign bus.md_result   = r_result;
  assign bus.md_stall    = bus.md_busy &
                           (bus.mult_en | bus.div_en | bus.hilo_rd | bus.hilo_wr);

  // Decode must never issue MULT and DIV in the same cycle.
  a_one_req: assert property (@(posedge clk) disable iff (reset)
                              !(bus.mult_en && bus.div_en));

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: directed corner ops plus random traffic.
module tb_md_scheduler;

  localparam int unsigned MUL_LAT = 2;

  typedef struct {
    logic [63:0] res;
    int unsigned start;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [63:0] exp_last = '0;

  md_if bus ();

  md_scheduler #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] model(bit is_div, bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!is_div) begin
      if (sgn) r = sa * sb;
      else     r = ua * ub;
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[31:0], sq[31:0]};
    end else begin
      r = {32'(ua % ub), 32'(ua / ub)};
    end
    return r;
  endfunction

  // Monitor: compare DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    bit          exp_busy, exp_cmp, exp_stall;
    if (reset) begin
      q.delete();
      exp_last = '0;
    end else begin
      exp_busy  = (q.size() > 0) && (cyc >= q[0].start) && (cyc <= q[0].due);
      exp_cmp   = (q.size() > 0) && (cyc == q[0].due);
      exp_stall = exp_busy & (bus.mult_en | bus.div_en | bus.hilo_rd | bus.hilo_wr);
      chk("busy", 64'(bus.md_busy), 64'(exp_busy));
      chk("stall", 64'(bus.md_stall), 64'(exp_stall));
      chk("complete", 64'(bus.md_complete), 64'(exp_cmp));
      if (exp_cmp) begin
        chk("result", bus.md_result, q[0].res);
        exp_last = q[0].res;
        void'(q.pop_front());
      end else begin
        chk("result_hold", bus.md_result, exp_last);
      end
    end
  end

  // Background MFHI/MTHI traffic exercising the stall term.
  initial begin
    bus.hilo_rd = 1'b0;
    bus.hilo_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.hilo_rd = ($urandom_range(0, 3) == 0);
      bus.hilo_wr = ($urandom_range(0, 7) == 0);
    end
  end

  task automatic issue(input bit is_div, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b, input bit with_flush);
    int w = 0;
    @(posedge clk);
    #1;
    while (bus.md_busy && w < 300) begin
      bus.flush = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 300) chk("idle_timeout", 64'(bus.md_busy), 64'd0);
    bus.flush     = with_flush;
    bus.mult_en   = ~is_div;
    bus.div_en    = is_div;
    bus.is_signed = sgn;
    bus.src1      = a;
    bus.src2      = b;
    if (!with_flush)
      q.push_back('{res: model(is_div, sgn, a, b), start: cyc + 1,
                    due: cyc + (is_div ? 33 : MUL_LAT + 1)});
    @(posedge clk);
    #1;
    bus.mult_en   = 1'b0;
    bus.div_en    = 1'b0;
    bus.flush     = 1'b0;
    bus.is_signed = 1'($urandom_range(0, 1));
    bus.src1      = $urandom;
    bus.src2      = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset         = 1'b1;
    bus.mult_en   = 1'b0;
    bus.div_en    = 1'b0;
    bus.is_signed = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(1'b1, 1'b0, 32'd7, 32'd2, 1'b0);
    issue(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 1'b1, 32'h0000_0009, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 32'd9, 32'd9, 1'b1);

    // Reset in DIV cycle 10 aborts the op; a following MULTU must still work.
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(1'b0, 1'b0, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 60; i++)
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
            ($urandom_range(0, 7) == 0));

    repeat (40) @(posedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
